// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the 16-bit combinational ALU: accepts load/execute
// commands, iterates the ALU on its own accumulator, and returns value and flags.
module alu_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   opb_reg;
    logic [2:0]         op_reg;
    logic [CNT_W-1:0]   iter_cnt;
    logic               carry;

    // ALU operands come straight from registers so they only move on clock edges
    assign alu_in_a   = acc;
    assign alu_in_b   = opb_reg;
    assign alu_opcode = op_reg;
    assign rsp_data   = acc;
    assign rsp_carry  = carry;
    assign rsp_zero   = (acc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            opb_reg   <= '0;
            op_reg    <= '0;
            iter_cnt  <= '0;
            carry     <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_load) begin
                            acc       <= cmd_data;
                            carry     <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            op_reg   <= cmd_op;
                            opb_reg  <= cmd_data;
                            iter_cnt <= (cmd_rep == '0) ? CNT_W'(1) : cmd_rep;
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    acc <= alu_result;
                    // carry-out is only defined by the ALU for ADD and SUB
                    if (op_reg == OP_ADD || op_reg == OP_SUB) begin
                        carry <= alu_cout;
                    end
                    iter_cnt <= iter_cnt - CNT_W'(1);
                    if (iter_cnt == CNT_W'(1)) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural ALU attached
// and a closed-form reference model of accumulator/carry per command.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_rep;
    logic [15:0] alu_in_a;
    logic [15:0] alu_in_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ref_acc;
    logic        ref_carry;

    alu_cmd_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rep(cmd_rep),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; cout for non-arithmetic ops is deliberately junk
    always_comb begin
        alu_result = '0;
        alu_cout   = ^alu_in_a;
        case (alu_opcode)
            3'b000: alu_result = ~alu_in_a;
            3'b001: alu_result = alu_in_a & alu_in_b;
            3'b010: alu_result = alu_in_a ^ alu_in_b;
            3'b011: alu_result = alu_in_a | alu_in_b;
            3'b100: alu_result = alu_in_a - 16'd1;
            3'b101: {alu_cout, alu_result} = {1'b0, alu_in_a} + {1'b0, alu_in_b};
            3'b110: {alu_cout, alu_result} = {1'b0, alu_in_a} - {1'b0, alu_in_b};
            default: alu_result = alu_in_a + 16'd1;
        endcase
    end

    // Reference: what a command does to (acc, carry), from the command rules
    task automatic ref_apply(input logic ld, input logic [2:0] op,
                             input logic [15:0] d, input logic [3:0] rep);
        int n;
        int a;
        n = (rep == 0) ? 1 : int'(rep);
        a = int'(ref_acc);
        if (ld) begin
            ref_acc   = d;
            ref_carry = 1'b0;
            return;
        end
        case (op)
            3'd0: if (n % 2 == 1) a = 65535 - a;
            3'd1: a = a & int'(d);
            3'd2: if (n % 2 == 1) a = a ^ int'(d);
            3'd3: a = a | int'(d);
            3'd4: a = (a - n + 65536) % 65536;
            3'd7: a = (a + n) % 65536;
            3'd5: for (int i = 0; i < n; i++) begin
                      a = a + int'(d);
                      ref_carry = (a >= 65536);
                      a = a % 65536;
                  end
            default: for (int i = 0; i < n; i++) begin
                      ref_carry = (a < int'(d));
                      a = (a - int'(d) + 65536) % 65536;
                  end
        endcase
        ref_acc = a[15:0];
    endtask

    // Stimulus only: issues one command, returns at the negedge rsp_valid is first seen
    task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [15:0] d,
                            input logic [3:0] rep, output int exec_cyc, output bit got);
        @(negedge clk);
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        cmd_rep   = rep;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_load  = 1'($urandom);
        cmd_op    = 3'($urandom);
        cmd_data  = 16'($urandom);
        cmd_rep   = 4'($urandom);
        exec_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            exec_cyc++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (alu_in_a !== 16'h0) begin n_fail++; $display("FAIL reset_alu_in_a got=%h exp=0", alu_in_a); end
        n_tests++; if ({alu_in_b, alu_opcode, rsp_carry} !== 20'h0) begin n_fail++; $display("FAIL reset_regs got=%h/%h/%b exp=0", alu_in_b, alu_opcode, rsp_carry); end
        n_tests++; if (rsp_zero !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_zero got=%b exp=1", rsp_zero); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        ref_acc = 16'h0;
        ref_carry = 1'b0;
    endtask

    task automatic test_directed();
        int ec;
        bit got;
        send_cmd(1'b1, 3'd0, 16'h1234, 4'd0, ec, got); finish_rsp();
        send_cmd(1'b0, 3'd5, 16'h0001, 4'd0, ec, got);
        n_tests++; if (!got || ec != 1) begin n_fail++; $display("FAIL add_latency got=%0d/%0d exp=1 exec cycle", got, ec); end
        n_tests++; if ({rsp_data, rsp_carry, rsp_zero} !== {16'h1235, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_basic got=%h c=%b z=%b exp=1235 c=0 z=0", rsp_data, rsp_carry, rsp_zero); end
        n_tests++; if (alu_in_b !== 16'h0001 || alu_opcode !== 3'd5) begin n_fail++; $display("FAIL alu_operands got=%h/%h exp=0001/5", alu_in_b, alu_opcode); end
        finish_rsp();
        send_cmd(1'b1, 3'd0, 16'hFFFF, 4'd0, ec, got);
        n_tests++; if (ec != 0 || rsp_data !== 16'hFFFF) begin n_fail++; $display("FAIL load got=%h cyc=%0d exp=ffff cyc=0", rsp_data, ec); end
        finish_rsp();
        send_cmd(1'b0, 3'd5, 16'h0001, 4'd1, ec, got);
        n_tests++; if ({rsp_data, rsp_carry, rsp_zero} !== {16'h0000, 1'b1, 1'b1}) begin n_fail++; $display("FAIL add_wrap got=%h c=%b z=%b exp=0000 c=1 z=1", rsp_data, rsp_carry, rsp_zero); end
        finish_rsp();
        send_cmd(1'b1, 3'd0, 16'h0002, 4'd0, ec, got);
        n_tests++; if (rsp_carry !== 1'b0) begin n_fail++; $display("FAIL load_clears_carry got=%b exp=0", rsp_carry); end
        finish_rsp();
        send_cmd(1'b0, 3'd6, 16'h0005, 4'd0, ec, got);
        n_tests++; if ({rsp_data, rsp_carry} !== {16'hFFFD, 1'b1}) begin n_fail++; $display("FAIL sub_borrow got=%h c=%b exp=fffd c=1", rsp_data, rsp_carry); end
        finish_rsp();
        send_cmd(1'b0, 3'd1, 16'h00F0, 4'd0, ec, got);
        n_tests++; if ({rsp_data, rsp_carry} !== {16'h00F0, 1'b1}) begin n_fail++; $display("FAIL and_holds_carry got=%h c=%b exp=00f0 c=1", rsp_data, rsp_carry); end
        finish_rsp();
        send_cmd(1'b1, 3'd0, 16'h0003, 4'd0, ec, got); finish_rsp();
        send_cmd(1'b0, 3'd7, 16'h0000, 4'd5, ec, got);
        n_tests++; if (ec != 5) begin n_fail++; $display("FAIL inc_rep_cycles got=%0d exp=5", ec); end
        n_tests++; if ({rsp_data, rsp_carry, busy} !== {16'h0008, 1'b0, 1'b1}) begin n_fail++; $display("FAIL inc_rep got=%h c=%b busy=%b exp=0008 c=0 busy=1", rsp_data, rsp_carry, busy); end
        finish_rsp();
        ref_acc = 16'h0008;
        ref_carry = 1'b0;
    endtask

    task automatic test_rsp_hold();
        int ec;
        bit got;
        send_cmd(1'b0, 3'd2, 16'h5A5A, 4'd1, ec, got);
        ref_apply(1'b0, 3'd2, 16'h5A5A, 4'd1);
        for (int i = 0; i < 4; i++) begin
            cmd_valid = i[0] ? 1'b0 : 1'b1;
            cmd_load  = 1'b1;
            cmd_data  = 16'hDEAD;
            @(negedge clk);
            n_tests++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== ref_acc) begin n_fail++; $display("FAIL hold_cycle%0d got v=%b r=%b d=%h exp v=1 r=0 d=%h", i, rsp_valid, cmd_ready, rsp_data, ref_acc); end
        end
        cmd_valid = 1'b0;
        finish_rsp();
        @(negedge clk);
        n_tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_data !== ref_acc) begin n_fail++; $display("FAIL hold_release got v=%b r=%b b=%b d=%h exp v=0 r=1 b=0 d=%h", rsp_valid, cmd_ready, busy, rsp_data, ref_acc); end
    endtask

    task automatic test_reset_mid();
        int ec;
        bit got;
        send_cmd(1'b1, 3'd0, 16'h0005, 4'd0, ec, got); finish_rsp();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd4; cmd_data = 16'h0000; cmd_rep = 4'd10;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (alu_in_a !== 16'h0003 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_before got=%h b=%b exp=0003 b=1", alu_in_a, busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({alu_in_a, alu_in_b, alu_opcode} !== 35'h0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset got a=%h op=%h v=%b b=%b r=%b exp zeros, ready=1", alu_in_a, alu_opcode, rsp_valid, busy, cmd_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_tests++; if (rsp_valid !== 1'b0 || alu_in_a !== 16'h0) begin n_fail++; $display("FAIL mid_after%0d got v=%b a=%h exp v=0 a=0000", i, rsp_valid, alu_in_a); end
        end
        ref_acc = 16'h0;
        ref_carry = 1'b0;
    endtask

    task automatic test_random();
        int ec;
        int exp_ec;
        bit got;
        logic ld;
        logic [2:0] op;
        logic [15:0] d;
        logic [3:0] rep;
        for (int t = 0; t < 40; t++) begin
            ld  = ($urandom_range(0, 4) == 0);
            op  = 3'($urandom);
            d   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rep = 4'($urandom);
            send_cmd(ld, op, d, rep, ec, got);
            ref_apply(ld, op, d, rep);
            exp_ec = ld ? 0 : ((rep == 0) ? 1 : int'(rep));
            n_tests++; if (!got || ec != exp_ec) begin n_fail++; $display("FAIL rand%0d_latency got=%0d/%0d exp=%0d", t, got, ec, exp_ec); end
            n_tests++; if (rsp_data !== ref_acc || rsp_carry !== ref_carry || rsp_zero !== (ref_acc == 16'h0)) begin n_fail++; $display("FAIL rand%0d ld=%b op=%0d d=%h rep=%0d got=%h c=%b z=%b exp=%h c=%b", t, ld, op, d, rep, rsp_data, rsp_carry, rsp_zero, ref_acc, ref_carry); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            finish_rsp();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0;
        cmd_data = 16'h0; cmd_rep = 4'd0; rsp_ready = 1'b0;
        ref_acc = 16'h0; ref_carry = 1'b0;
        test_reset();
        test_directed();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
